// File: rtl/wave_capture_trig_pkg.sv
// Shared encodings for the triggered waveform capture block.
// The FSM state is visible on a debug port; trigger modes come from a 2-bit control input.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_WAITING = 2'b10
  } wave_state_t;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_FREE = 2'b10;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_capture_trig_trig_detect.sv
// Trigger detector: remembers the previous sample, compares against a signed level
// and counts ARMED samples for the auto-trigger timeout.
module trig_detect
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic [1:0]          trig_mode,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                armed,
  input  logic                clear_prev,
  output logic                trigger,
  output logic                is_timeout,
  output logic                level_hit
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic signed [SAMPLE_W-1:0] prev_sample;
  logic signed [SAMPLE_W-1:0] new_s;
  logic signed [SAMPLE_W-1:0] lvl_s;
  logic                       prev_valid;
  logic [CNT_W-1:0]           timeout_cnt;

  assign new_s = new_sample_in;
  assign lvl_s = trig_level;

  always_comb begin
    level_hit = 1'b0;
    case (trig_mode)
      TRIG_FALL: level_hit = prev_valid && (prev_sample >= lvl_s) && (new_s < lvl_s);
      TRIG_FREE: level_hit = 1'b1;
      default:   level_hit = prev_valid && (prev_sample < lvl_s) && (new_s >= lvl_s);
    endcase
    is_timeout = (TIMEOUT != 0) && (timeout_cnt == TO_LAST);
    trigger    = armed && new_sample_ready && (level_hit || is_timeout);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      if (new_sample_ready) begin
        prev_sample <= new_s;
        prev_valid  <= 1'b1;
      end
      // Dropping prev_valid at capture end forces a fresh pair after re-arm.
      if (clear_prev) prev_valid <= 1'b0;
      if (!armed || trigger) begin
        timeout_cnt <= '0;
      end else if (new_sample_ready && (timeout_cnt != '1)) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wave_capture_trig.sv
// Triggered, decimating capture of a sample stream into one half of a ping-pong
// display RAM; swaps halves once the display reports idle.
module wave_capture_trig
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int ADDR_W   = 8,
  parameter int DECIM_W  = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic [1:0]          trig_mode,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                wave_display_idle,
  output logic [ADDR_W:0]     write_address,
  output logic                write_enable,
  output logic [OUT_W-1:0]    write_sample,
  output logic                read_index,
  output logic                capture_done,
  output logic                auto_triggered,
  output logic [1:0]          state
);

  // Handshake: new_sample_ready is a one-cycle valid strobe with no ready/backpressure;
  // each strobe is consumed on the edge that samples it, and write_enable is the
  // same-cycle RAM write strobe for that sample.

  localparam logic [OUT_W-1:0] MSB_MASK = OUT_W'(1) << (OUT_W - 1);

  wave_state_t          st;
  logic [ADDR_W-1:0]    index;
  logic [DECIM_W-1:0]   decim_cnt;
  logic [DECIM_W-1:0]   decim_latched;
  logic                 trigger;
  logic                 is_timeout;
  logic                 level_hit;
  logic                 decim_hit;
  logic                 last_write;
  logic [OUT_W-1:0]     raw_sample;

  assign decim_hit  = (st == ST_ACTIVE) && new_sample_ready && (decim_cnt == decim_latched);
  assign last_write = decim_hit && (index == '1);

  trig_detect #(
    .SAMPLE_W (SAMPLE_W),
    .TIMEOUT  (TIMEOUT)
  ) u_trig (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .trig_mode        (trig_mode),
    .trig_level       (trig_level),
    .armed            (st == ST_ARMED),
    .clear_prev       (last_write),
    .trigger          (trigger),
    .is_timeout       (is_timeout),
    .level_hit        (level_hit)
  );

  // Signed to offset binary: keep the top OUT_W bits and flip the sign bit.
  assign raw_sample    = new_sample_in[SAMPLE_W-1 -: OUT_W];
  assign write_sample  = raw_sample ^ MSB_MASK;
  assign write_address = {~read_index, index};
  assign write_enable  = reset && (trigger || decim_hit);
  assign state         = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st             <= ST_ARMED;
      read_index     <= 1'b0;
      index          <= '0;
      decim_cnt      <= '0;
      decim_latched  <= '0;
      capture_done   <= 1'b0;
      auto_triggered <= 1'b0;
    end else begin
      capture_done <= 1'b0;
      case (st)
        ST_ARMED: begin
          if (trigger) begin
            index          <= ADDR_W'(1);
            decim_cnt      <= '0;
            decim_latched  <= decim;
            auto_triggered <= is_timeout && !level_hit;
            st             <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (new_sample_ready) begin
            if (decim_cnt == decim_latched) begin
              index     <= index + ADDR_W'(1);
              decim_cnt <= '0;
              if (index == '1) begin
                st           <= ST_WAITING;
                capture_done <= 1'b1;
              end
            end else begin
              decim_cnt <= decim_cnt + DECIM_W'(1);
            end
          end
        end
        ST_WAITING: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            st         <= ST_ARMED;
          end
        end
        default: st <= ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_trig.sv
// Bench for wave_capture_trig: per-cycle reference model feeding an expected-write
// queue, plus directed trigger, timeout, decimation and reset scenarios.
module tb_wave_capture_trig;

  localparam int SAMPLE_W = 16;
  localparam int OUT_W    = 8;
  localparam int ADDR_W   = 8;
  localparam int DECIM_W  = 4;
  localparam int TIMEOUT  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic [1:0]          trig_mode;
  logic [SAMPLE_W-1:0] trig_level;
  logic [DECIM_W-1:0]  decim;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [OUT_W-1:0]    write_sample;
  logic                read_index;
  logic                capture_done;
  logic                auto_triggered;
  logic [1:0]          state;

  always #5 clk = ~clk;

  wave_capture_trig #(
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .ADDR_W   (ADDR_W),
    .DECIM_W  (DECIM_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .trig_mode         (trig_mode),
    .trig_level        (trig_level),
    .decim             (decim),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .capture_done      (capture_done),
    .auto_triggered    (auto_triggered),
    .state             (state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];
  bit mon_on = 1'b0;

  logic [1:0]         m_state;
  logic               m_ri;
  int                 m_idx;
  int                 m_dcnt;
  int                 m_dlat;
  logic signed [15:0] m_prev;
  logic               m_pv;
  int                 m_tcnt;
  logic               m_cd;
  logic               m_auto;
  logic               m_we;
  logic               c_trig, c_hit, c_lvl, c_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected combinational outputs for the inputs currently driven.
  task automatic model_comb();
    logic signed [15:0] s;
    logic signed [15:0] lv;
    logic [15:0]        su;
    s  = new_sample_in;
    su = new_sample_in;
    lv = trig_level;
    case (trig_mode)
      2'b01:   c_lvl = m_pv && (m_prev >= lv) && (s < lv);
      2'b10:   c_lvl = 1'b1;
      default: c_lvl = m_pv && (m_prev < lv) && (s >= lv);
    endcase
    c_to   = (m_tcnt == TIMEOUT - 1);
    c_trig = new_sample_ready && (m_state == 2'b00) && (c_lvl || c_to);
    c_hit  = new_sample_ready && (m_state == 2'b01) && (m_dcnt == m_dlat);
    m_we   = reset && (c_trig || c_hit);
    if (m_we) exp_q.push_back({~m_ri, m_idx[7:0], ~su[15], su[14:8]});
  endtask

  // Register update at the clock edge, using the inputs that were sampled.
  task automatic model_seq();
    if (!reset) begin
      m_state = 2'b00; m_ri = 1'b0; m_idx = 0; m_dcnt = 0; m_dlat = 0;
      m_prev = '0; m_pv = 1'b0; m_tcnt = 0; m_cd = 1'b0; m_auto = 1'b0;
    end else begin
      m_cd = 1'b0;
      if (new_sample_ready) begin
        m_prev = new_sample_in;
        m_pv   = 1'b1;
      end
      case (m_state)
        2'b00: begin
          if (c_trig) begin
            m_idx = 1; m_dcnt = 0; m_dlat = int'(decim); m_state = 2'b01;
            m_auto = c_to && !c_lvl; m_tcnt = 0;
          end else if (new_sample_ready) begin
            m_tcnt++;
          end
        end
        2'b01: begin
          if (new_sample_ready) begin
            if (c_hit) begin
              m_dcnt = 0;
              if (m_idx == 255) begin
                m_idx = 0; m_state = 2'b10; m_cd = 1'b1; m_pv = 1'b0;
              end else begin
                m_idx++;
              end
            end else begin
              m_dcnt++;
            end
          end
        end
        default: begin
          if (wave_display_idle) begin
            m_ri = ~m_ri; m_state = 2'b00; m_tcnt = 0;
          end
        end
      endcase
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [16:0] w;
      check("state", state, m_state);
      check("read_index", read_index, m_ri);
      check("capture_done", capture_done, m_cd);
      check("auto_triggered", auto_triggered, m_auto);
      check("write_enable", write_enable, m_we);
      if (m_we) begin
        w = exp_q.pop_front();
        check("write_word", {write_address, write_sample}, w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rdy, input logic [15:0] s, input logic idl, input logic rst);
    reset = rst; new_sample_ready = rdy; new_sample_in = s; wave_display_idle = idl;
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    cycle(1'b1, s, 1'b0, 1'b1);
    if ($urandom_range(0, 3) == 0) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) send(16'($urandom_range(0, 65535)));
  endtask

  // Drive a sample that must trigger, checking the write against fixed values.
  task automatic strobe_expect(input logic [15:0] s, input logic [16:0] word);
    reset = 1'b1; new_sample_ready = 1'b1; new_sample_in = s; wave_display_idle = 1'b0;
    model_comb();
    #2;
    check("trig_we", write_enable, 1'b1);
    check("trig_word", {write_address, write_sample}, word);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic finish_capture();
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("end_state", state, 2'b10);
    check("end_queue", exp_q.size(), 0);
  endtask

  task automatic release_display(input int n);
    repeat (n) cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    trig_mode = 2'b00; trig_level = '0; decim = '0;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    mon_on = 1'b1;
    cycle(1'b1, 16'h8000, 1'b0, 1'b0);
    cycle(1'b1, 16'h0010, 1'b0, 1'b0);
    check("rst_state", state, 2'b00);
    check("rst_read_index", read_index, 1'b0);

    // Rising through zero, first write into upper half.
    send(16'hF000);
    send(16'hFFF0);
    strobe_expect(16'h0010, {9'h100, 8'h80});
    fill(255);
    finish_capture();

    // Idle held 10 cycles: exactly one swap.
    release_display(10);
    check("swap_once", read_index, 1'b1);

    send(16'hFF00);
    strobe_expect(16'h0100, {9'h000, 8'h81});
    fill(255);
    finish_capture();
    release_display(3);

    // Falling through 0x1000; the rising step must not trigger.
    trig_mode = 2'b01; trig_level = 16'h1000;
    send(16'h0800);
    send(16'h2000);
    strobe_expect(16'h0800, {9'h100, 8'h88});
    fill(255);
    finish_capture();
    release_display(2);

    // Constant input in rising mode: timeout fires on the 16th ARMED sample.
    trig_mode = 2'b00; trig_level = '0;
    repeat (15) send(16'h0100);
    strobe_expect(16'h0100, {9'h000, 8'h81});
    check("auto_set", auto_triggered, 1'b1);
    fill(255);
    finish_capture();
    release_display(1);

    // Genuine crossing clears auto_triggered.
    send(16'hFFFB);
    strobe_expect(16'h0005, {9'h100, 8'h80});
    check("auto_clear", auto_triggered, 1'b0);
    fill(255);
    finish_capture();
    release_display(4);

    // Free-run capture abandoned by reset at index 100.
    trig_mode = 2'b10; decim = '0;
    strobe_expect(16'h7FFF, {9'h000, 8'hFF});
    fill(99);
    cycle(1'b1, 16'h4321, 1'b0, 1'b0);
    check("abort_state", state, 2'b00);
    check("abort_read_index", read_index, 1'b0);

    // Decimation by 4, restarting at index 0; a mid-capture decim change is ignored.
    decim = 4'd3;
    strobe_expect(16'h8000, {9'h100, 8'h00});
    for (int i = 1; i <= 1020; i++) begin
      if (i == 10) decim = 4'd0;
      send(16'($urandom_range(0, 65535)));
    end
    finish_capture();
    release_display(2);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_capture_trig.md
Name: wave_capture_trig

Overview:
- Parametrised successor to the single-mode audio scope capture block.
- Watches the sample stream for a programmable trigger, then writes DEPTH decimated samples into one half of a ping-pong display RAM.
- Then waits for the display to go idle and swaps halves.
- Sits between the codec sample path and wave_display.
- Adds rising/falling/free-run trigger modes, signed threshold level, auto-trigger timeout and sample decimation.

Parameters:
- SAMPLE_W, 16, input sample width (signed two's complement)
- OUT_W, 8, stored sample width (OUT_W <= SAMPLE_W)
- ADDR_W, 8, log2 of capture depth per RAM half; DEPTH = 2**ADDR_W
- DECIM_W, 4, width of decimation control
- TIMEOUT, 4096, ARMED samples before forced trigger; 0 disables auto-trigger

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- new_sample_ready  in  1  one-cycle strobe, new_sample_in valid
- new_sample_in  in  SAMPLE_W  signed sample
- trig_mode  in  2  00 rising, 01 falling, 10 free-run, 11 reserved (treated as rising)
- trig_level  in  SAMPLE_W  signed threshold
- decim  in  DECIM_W  keep 1 of every decim+1 samples after trigger
- wave_display_idle  in  1  display finished reading its half
- write_address  out  ADDR_W+1  {~read_index, index}
- write_enable  out  1  RAM write strobe
- write_sample  out  OUT_W  offset-binary sample
- read_index  out  1  half currently owned by display
- capture_done  out  1  one-cycle pulse on entering WAITING
- auto_triggered  out  1  last capture was started by timeout
- state  out  2  debug: 00 ARMED, 01 ACTIVE, 10 WAITING

Behaviour:
- Reset (reset==0 at clk edge) has priority over everything:
  - state=ARMED, read_index=0, index=0, decim_cnt=0, timeout_cnt=0.
  - prev_sample=0, prev_valid=0, capture_done=0, auto_triggered=0.
  - While reset==0, write_enable is forced 0.
- prev_sample/prev_valid:
  - On every new_sample_ready, in any state: prev_sample<=new_sample_in, prev_valid<=1.
  - On ACTIVE->WAITING, prev_valid<=0, so a fresh comparison pair is required after re-arm.
- Trigger is combinational, valid only in ARMED with new_sample_ready=1 (signed compares):
  - rising: prev_valid & prev_sample < trig_level & new_sample_in >= trig_level
  - falling: prev_valid & prev_sample >= trig_level & new_sample_in < trig_level
  - free-run: trigger on first sample seen in ARMED
  - timeout: TIMEOUT!=0 & timeout_cnt==TIMEOUT-1, independent of mode
- timeout_cnt:
  - Increments per sample in ARMED; cleared on trigger and on entering ARMED.
  - Saturates; no wrap.
- ARMED:
  - On trigger: write the triggering sample at index 0 in that same cycle.
  - Then index<=1, decim_cnt<=0, latch decim, state<=ACTIVE.
  - auto_triggered<=1 if the trigger came from timeout only, else 0. A simultaneous level trigger wins and gives 0.
- ACTIVE, on each new_sample_ready:
  - If decim_cnt==decim_latched: write at index, index++, decim_cnt<=0.
  - Else decim_cnt++, no write.
  - The write at index DEPTH-1 moves state to WAITING and pulses capture_done next cycle. index wraps to 0.
- write_enable = reset & new_sample_ready & (ARMED&trigger | ACTIVE&decim hit). Combinational, same cycle as strobe. Never high in WAITING.
- write_sample = new_sample_in[SAMPLE_W-1 -: OUT_W] with MSB inverted (signed -> offset binary). 0x8000 -> 0x00; 0x7FFF -> 0xFF; 0x0000 -> 0x80.
- WAITING:
  - Samples ignored except the prev_sample update.
  - On wave_display_idle=1: read_index toggles and state<=ARMED in the same edge.
  - idle held high causes exactly one toggle per capture.
- Config changes:
  - trig_mode/trig_level act live in ARMED.
  - decim changes during ACTIVE take effect on the next capture only.
- Reset mid-ACTIVE: capture is abandoned, read_index returns to 0, no further writes.

Decomposition:
- Shared package wave_pkg: state encodings ARMED/ACTIVE/WAITING, trig_mode encodings TRIG_RISE/TRIG_FALL/TRIG_FREE.
- One natural sub-module: trig_detect, holding prev_sample/prev_valid, the level compare and the timeout counter, with a trigger and is_timeout output.
- FSM, index and decimation stay in the top.

Test Plan:
- Reset then rising, level 0, decim 0, sine -> write_enable first on sample 0x0010 after 0xFFF0, at address 0x100. Then 256 consecutive writes ending at 0x1FF, capture_done pulse, state=WAITING.
- WAITING with idle=1 held 10 cycles -> read_index 0->1 exactly once. Next capture writes addresses 0x000-0x0FF.
- Falling, level 0x1000, input steps 0x2000 -> 0x0800 -> write at index 0 with write_sample=0x88. Input 0x0800 -> 0x2000 causes no trigger.
- TIMEOUT=16, constant input 0x0100, rising mode -> trigger on 16th ARMED sample, auto_triggered=1. A following genuine crossing capture gives auto_triggered=0.
- decim=3, free-run -> writes on samples 0, 4, 8, ...; 256 writes span 1021 strobes. write_enable is 0 on the other strobes.
- reset=0 during ACTIVE at index 100 -> next cycle state=ARMED, read_index=0, write_enable=0. Next trigger restarts at index 0.
